// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory-to-UART streamer: FSM state encoding and byte width.
package mem_stream_reader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// RAM read port plus byte stream towards the UART transmitter.
interface mem_stream_reader_if
  import mem_stream_reader_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 8
) ();

  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_addr,
    input  mem_rdata,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/mem_stream_reader_word_byte_ser.sv
// Loads one RAM word and presents it as a valid/ready byte stream, least significant byte first.
module word_byte_ser
  import mem_stream_reader_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DW-1:0]     word,
  input  logic              ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              valid,
  output logic              last
);

  localparam int NBYTES = DW / BYTE_W;

  logic [DW-1:0] shreg;
  logic [3:0]    cnt;
  logic          accept;

  assign accept   = valid && ready;
  assign byte_out = shreg[BYTE_W-1:0];
  assign last     = (cnt == 4'(NBYTES - 1));

  // clr outranks a same-cycle accept, so an aborted byte never counts as sent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (accept) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        shreg <= shreg >> BYTE_W;
        cnt   <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Streams RAM words [start_addr..end_addr] to the UART Tx as bytes, LSB byte first.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int AW     = 18,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic          busy,
  output logic          fin,
  output logic          err,
  output logic          aborted,
  mem_stream_reader_if.master bus
);

  state_t            state;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     end_l;
  logic [2:0]        lat_cnt;
  logic              cap;
  logic              ser_load;
  logic              ser_clr;
  logic              ser_valid;
  logic              ser_last;
  logic [BYTE_W-1:0] ser_byte;

  assign cap      = (state == ST_FETCH) && (lat_cnt == 3'(RD_LAT));
  assign ser_clr  = abort && (state != ST_IDLE);
  assign ser_load = cap && !abort;

  assign bus.mem_addr = addr_q;
  assign bus.tx_data  = ser_byte;
  assign bus.tx_valid = ser_valid;

  word_byte_ser #(.DW(DW)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .clr      (ser_clr),
    .word     (bus.mem_rdata),
    .ready    (bus.tx_ready),
    .byte_out (ser_byte),
    .valid    (ser_valid),
    .last     (ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      end_l   <= '0;
      lat_cnt <= '0;
      busy    <= 1'b0;
      fin     <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
    end else begin
      fin     <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              if (end_addr < start_addr) begin
                err <= 1'b1;
              end else begin
                end_l   <= end_addr;
                addr_q  <= start_addr;
                lat_cnt <= '0;
                busy    <= 1'b1;
                state   <= ST_FETCH;
              end
            end
          end
          // RAM data is valid RD_LAT cycles after the address; capture one cycle later
          ST_FETCH: begin
            if (cap) state <= ST_SEND;
            else     lat_cnt <= lat_cnt + 3'd1;
          end
          ST_SEND: begin
            if (ser_valid && bus.tx_ready && ser_last) state <= ST_NEXT;
          end
          // Compare before incrementing so the top of the address space never wraps
          ST_NEXT: begin
            if (addr_q == end_l) begin
              state <= ST_DONE;
            end else begin
              addr_q  <= addr_q + AW'(1);
              lat_cnt <= '0;
              state   <= ST_FETCH;
            end
          end
          ST_DONE: begin
            fin   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench: an 8-bit/RD_LAT=1 instance and a 32-bit/RD_LAT=2 instance driven with directed vectors.
module tb_mem_stream_reader;
  import mem_stream_reader_pkg::*;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start_a, abort_a, busy_a, fin_a, err_a, aborted_a;
  logic          start_b, abort_b, busy_b, fin_b, err_b, aborted_b;
  logic [AW-1:0] sa_a, ea_a, sa_b, ea_b;

  mem_stream_reader_if #(.AW(AW), .DW(8))  ifa ();
  mem_stream_reader_if #(.AW(AW), .DW(32)) ifb ();

  mem_stream_reader #(.AW(AW), .DW(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .start_addr(sa_a), .end_addr(ea_a), .busy(busy_a), .fin(fin_a),
    .err(err_a), .aborted(aborted_a), .bus(ifa.master)
  );

  mem_stream_reader #(.AW(AW), .DW(32), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .start_addr(sa_b), .end_addr(ea_b), .busy(busy_b), .fin(fin_b),
    .err(err_b), .aborted(aborted_b), .bus(ifb.master)
  );

  function automatic logic [31:0] ram_b_word(input logic [AW-1:0] a);
    case (a)
      18'd5:   return 32'h44332211;
      18'd6:   return 32'h88776655;
      18'd7:   return 32'hCCBBAA99;
      default: return 32'h0;
    endcase
  endfunction

  // RAM models: A has one cycle of latency, B two
  logic [31:0] rd_b_p0;
  always @(posedge clk) begin
    ifa.mem_rdata <= 8'hA0 + ifa.mem_addr[7:0];
    rd_b_p0       <= ram_b_word(ifb.mem_addr);
    ifb.mem_rdata <= rd_b_p0;
  end

  int n_tests, n_fail;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int fin_cnt_a, err_cnt_a, abt_cnt_a, vld_cnt_a, busy_cnt_a, zero_cnt_a;
  int fin_cnt_b, abt_cnt_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    logic       hold_b;
    logic [7:0] held_b;
    hold_b = 1'b0;
    held_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_b = 1'b0;
        continue;
      end
      if (fin_a)     fin_cnt_a++;
      if (err_a)     err_cnt_a++;
      if (aborted_a) abt_cnt_a++;
      if (ifa.tx_valid) vld_cnt_a++;
      if (busy_a) busy_cnt_a++;
      if (busy_a && ifa.mem_addr == '0) zero_cnt_a++;
      if (fin_b)     fin_cnt_b++;
      if (aborted_b) abt_cnt_b++;
      if (ifa.tx_valid && ifa.tx_ready && !abort_a) begin
        if (exp_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL byte_a: got unexpected byte %02h, required none", ifa.tx_data);
        end else chk("byte_a", ifa.tx_data, exp_a.pop_front());
      end
      if (ifb.tx_valid && ifb.tx_ready && !abort_b) begin
        if (exp_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL byte_b: got unexpected byte %02h, required none", ifb.tx_data);
        end else chk("byte_b", ifb.tx_data, exp_b.pop_front());
      end
      if (hold_b) begin
        chk("hold_valid_b", ifb.tx_valid, 1);
        chk("hold_data_b", ifb.tx_data, held_b);
      end
      hold_b = ifb.tx_valid && !ifb.tx_ready && !abort_b;
      held_b = ifb.tx_data;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_a(input logic [AW-1:0] s, input logic [AW-1:0] e);
    sa_a = s; ea_a = e; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [AW-1:0] s, input logic [AW-1:0] e);
    sa_b = s; ea_b = e; start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
  endtask

  task automatic wait_fin(input bit sel, input int base, input int budget, input string name);
    int i;
    i = 0;
    while ((sel ? fin_cnt_b : fin_cnt_a) == base && i < budget) begin
      tick(1);
      i++;
    end
    tick(2);
    chk(name, (sel ? fin_cnt_b : fin_cnt_a) - base, 1);
    chk({name, "_busy"}, sel ? busy_b : busy_a, 0);
  endtask

  task automatic wait_valid_b(input int budget);
    int i;
    i = 0;
    while (!ifb.tx_valid && i < budget) begin
      tick(1);
      i++;
    end
    chk("wait_valid_b", ifb.tx_valid, 1);
  endtask

  initial begin
    int base, b2, b3;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; sa_a = '0; ea_a = '0;
    start_b = 1'b0; abort_b = 1'b0; sa_b = '0; ea_b = '0;
    ifa.tx_ready = 1'b1; ifb.tx_ready = 1'b1;
    fork monitor(); join_none
    tick(3);
    chk("rst_addr_a", ifa.mem_addr, 0);
    chk("rst_data_a", ifa.tx_data, 0);
    chk("rst_valid_a", ifa.tx_valid, 0);
    chk("rst_flags_a", {busy_a, fin_a, err_a, aborted_a}, 0);
    chk("rst_valid_b", ifb.tx_valid, 0);
    chk("rst_flags_b", {busy_b, fin_b, err_b, aborted_b}, 0);
    rst_n = 1'b1;
    tick(2);

    // four single-byte words, free-running sink
    exp_a.push_back(8'hA0); exp_a.push_back(8'hA1);
    exp_a.push_back(8'hA2); exp_a.push_back(8'hA3);
    base = fin_cnt_a;
    go_a(18'd0, 18'd3);
    wait_fin(1'b0, base, 100, "fin_t1");
    chk("q_a_t1", exp_a.size(), 0);

    // one 32-bit word, start == end
    exp_b.push_back(8'h11); exp_b.push_back(8'h22);
    exp_b.push_back(8'h33); exp_b.push_back(8'h44);
    base = fin_cnt_b;
    go_b(18'd5, 18'd5);
    wait_fin(1'b1, base, 100, "fin_t2");
    chk("q_b_t2", exp_b.size(), 0);

    // stalled then randomly toggled sink
    exp_b.push_back(8'h55); exp_b.push_back(8'h66); exp_b.push_back(8'h77); exp_b.push_back(8'h88);
    exp_b.push_back(8'h99); exp_b.push_back(8'hAA); exp_b.push_back(8'hBB); exp_b.push_back(8'hCC);
    ifb.tx_ready = 1'b0;
    base = fin_cnt_b;
    go_b(18'd6, 18'd7);
    wait_valid_b(20);
    tick(20);
    chk("stall_valid_b", ifb.tx_valid, 1);
    chk("stall_data_b", ifb.tx_data, 8'h55);
    for (int i = 0; i < 60; i++) begin
      ifb.tx_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    ifb.tx_ready = 1'b1;
    wait_fin(1'b1, base, 100, "fin_t3");
    chk("q_b_t3", exp_b.size(), 0);

    // reversed range is rejected
    base = err_cnt_a; b2 = vld_cnt_a; b3 = busy_cnt_a;
    go_a(18'd10, 18'd9);
    tick(4);
    chk("err_pulse", err_cnt_a - base, 1);
    chk("err_no_valid", vld_cnt_a - b2, 0);
    chk("err_no_busy", busy_cnt_a - b3, 0);

    // abort together with start in IDLE: nothing starts, no pulse
    base = err_cnt_a; b2 = busy_cnt_a; b3 = abt_cnt_a;
    abort_a = 1'b1;
    go_a(18'd0, 18'd3);
    abort_a = 1'b0;
    tick(4);
    chk("abst_no_busy", busy_cnt_a - b2, 0);
    chk("abst_no_pulse", (err_cnt_a - base) + (abt_cnt_a - b3), 0);

    // top of the address space
    exp_a.push_back(8'h9E); exp_a.push_back(8'h9F);
    b2 = zero_cnt_a;
    base = fin_cnt_a;
    go_a(18'h3FFFE, 18'h3FFFF);
    wait_fin(1'b0, base, 100, "fin_t5");
    chk("no_wrap", zero_cnt_a - b2, 0);
    chk("end_addr_a", ifa.mem_addr, 18'h3FFFF);
    chk("q_a_t5", exp_a.size(), 0);

    // abort while the third byte is pending, with tx_ready high
    exp_b.push_back(8'h11); exp_b.push_back(8'h22);
    ifb.tx_ready = 1'b0;
    base = fin_cnt_b; b2 = abt_cnt_b;
    go_b(18'd5, 18'd5);
    wait_valid_b(20);
    ifb.tx_ready = 1'b1;
    tick(2);
    chk("third_byte_b", ifb.tx_data, 8'h33);
    abort_b = 1'b1;
    tick(1);
    abort_b = 1'b0;
    chk("abort_valid_b", ifb.tx_valid, 0);
    chk("abort_pulse_b", aborted_b, 1);
    chk("abort_busy_b", busy_b, 0);
    tick(3);
    chk("abort_cnt_b", abt_cnt_b - b2, 1);
    chk("abort_no_fin_b", fin_cnt_b - base, 0);
    chk("q_b_abort", exp_b.size(), 0);

    exp_b.push_back(8'h11); exp_b.push_back(8'h22);
    exp_b.push_back(8'h33); exp_b.push_back(8'h44);
    base = fin_cnt_b;
    go_b(18'd5, 18'd5);
    wait_fin(1'b1, base, 100, "fin_t6");
    chk("q_b_t6", exp_b.size(), 0);

    // asynchronous reset while fetching
    base = fin_cnt_a; b2 = abt_cnt_a;
    go_a(18'd2, 18'd3);
    chk("fetch_addr_a", ifa.mem_addr, 18'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", ifa.mem_addr, 0);
    chk("mid_rst_data", ifa.tx_data, 0);
    chk("mid_rst_valid", ifa.tx_valid, 0);
    chk("mid_rst_flags", {busy_a, fin_a, err_a, aborted_a}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_no_fin", fin_cnt_a - base, 0);
    chk("rst_no_abort", abt_cnt_a - b2, 0);

    exp_a.push_back(8'hA0); exp_a.push_back(8'hA1);
    exp_a.push_back(8'hA2); exp_a.push_back(8'hA3);
    base = fin_cnt_a;
    go_a(18'd0, 18'd3);
    wait_fin(1'b0, base, 100, "fin_t7");
    chk("q_a_t7", exp_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
